// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the program counter, fetches one instruction per step over
// a req/ack handshake, and holds it for the core until advance is signalled.
//
// state | meaning
// FETCH | request outstanding at pc, waiting for imem_ack
// VALID | instruction held and presented, waiting for advance
// FAULT | misaligned redirect target taken; parked until reset
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000  // must be a multiple of 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        req_q;
  logic        valid_q;
  logic        fault_q;

  // Fetch sequencer: pc, instruction register and registered status outputs.
  // instr_q is cleared whenever VALID is left so the decoder sees opcode 0
  // (no side effects) while a fetch is in flight or after a fault.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
      req_q   <= 1'b1;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state   <= VALID;
          end
        end
        VALID: begin
          // imem_ack is ignored here; advance alone moves the stage on.
          if (advance) begin
            instr_q <= 32'h0000_0000;
            valid_q <= 1'b0;
            if (redirect) begin
              pc_q <= redirect_pc;
              if (redirect_pc[1:0] != 2'b00) begin
                req_q   <= 1'b0;
                fault_q <= 1'b1;
                state   <= FAULT;
              end else begin
                req_q <= 1'b1;
                state <= FETCH;
              end
            end else begin
              pc_q  <= pc_plus4;
              req_q <= 1'b1;
              state <= FETCH;
            end
          end
        end
        FAULT: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          fault_q <= 1'b1;
        end
        default: begin
          state   <= FETCH;
          instr_q <= 32'h0000_0000;
          req_q   <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // The request flop resets to 1 so the first request appears as soon as
  // reset drops; gating with reset keeps it low while reset is held.
  assign imem_req    = req_q & ~reset;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr       = instr_q;
  assign opcode      = instr_q[6:0];
  assign instr_valid = valid_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: table-driven fetch steps with
// a scoreboard of expected instructions, plus hand-written reset, wrap and
// misaligned-redirect sequences. A second instance starts at 32'hFFFF_FFFC.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        advance;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        imem_req, instr_valid, fetch_fault;
  logic [31:0] imem_addr, instr, pc, pc_plus4;
  logic [6:0]  opcode;

  logic        u1_req, u1_valid, u1_fault;
  logic [31:0] u1_addr, u1_instr, u1_pc, u1_pc_plus4;
  logic [6:0]  u1_opcode;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    int          lat;
    int          hold;
    bit          redir;
    logic [31:0] tgt;
    logic [31:0] addr;
  } vec_t;
  vec_t vecs[9];

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) u0 (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .advance(advance),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr(instr),
    .opcode(opcode), .pc(pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid),
    .fetch_fault(fetch_fault)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u1 (
    .clk(clk), .reset(reset), .imem_req(u1_req), .imem_addr(u1_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .advance(advance),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr(u1_instr),
    .opcode(u1_opcode), .pc(u1_pc), .pc_plus4(u1_pc_plus4), .instr_valid(u1_valid),
    .fetch_fault(u1_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[24:0], 7'h13 ^ a[8:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Entered just after a negedge with the DUT heading for FETCH at addr.
  task automatic do_step(input int lat, input int hold, input bit redir,
                         input logic [31:0] tgt, input logic [31:0] addr);
    int   n;
    exp_t e;
    n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("req_timeout", 32'd0, 32'd1);
      return;
    end
    chk("fetch_addr", imem_addr, addr);
    chk("gap_instr", instr, 32'h0);
    chk("gap_valid", {31'b0, instr_valid}, 32'd0);
    repeat (lat) begin
      @(negedge clk);
      chk("addr_stable", imem_addr, addr);
    end
    imem_ack   = 1'b1;
    imem_rdata = mem_word(addr);
    sbq.push_back('{pc: addr, instr: mem_word(addr)});
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk("valid_rise", {31'b0, instr_valid}, 32'd1);
    chk("req_low_valid", {31'b0, imem_req}, 32'd0);
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sbq.pop_front();
    chk("instr", instr, e.instr);
    chk("opcode", {25'b0, opcode}, {25'b0, e.instr[6:0]});
    chk("pc", pc, e.pc);
    chk("pc_plus4", pc_plus4, e.pc + 32'd4);
    chk("no_fault", {31'b0, fetch_fault}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      advance     = 1'b0;
      redirect    = redir;
      redirect_pc = tgt;
      imem_ack    = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("hold_valid", {31'b0, instr_valid}, 32'd1);
      chk("hold_pc", pc, e.pc);
      chk("hold_instr", instr, e.instr);
    end
    advance     = 1'b1;
    redirect    = redir;
    redirect_pc = tgt;
    @(negedge clk);
    advance  = 1'b0;
    redirect = 1'b0;
    imem_ack = 1'b0;
    chk("adv_valid", {31'b0, instr_valid}, 32'd0);
    chk("adv_instr", instr, 32'h0);
    chk("adv_req", {31'b0, imem_req}, (redir && tgt[1:0] != 2'b00) ? 32'd0 : 32'd1);
  endtask

  initial begin
    vecs[0] = '{2, 0, 1'b0, 32'h0,          32'h0000_0000};
    vecs[1] = '{0, 0, 1'b0, 32'h0,          32'h0000_0004};
    vecs[2] = '{0, 0, 1'b0, 32'h0,          32'h0000_0008};
    vecs[3] = '{0, 3, 1'b1, 32'h0000_0100,  32'h0000_000C};
    vecs[4] = '{1, 0, 1'b0, 32'h0,          32'h0000_0100};
    vecs[5] = '{0, 1, 1'b1, 32'hFFFF_FFF8,  32'h0000_0104};
    vecs[6] = '{0, 0, 1'b0, 32'h0,          32'hFFFF_FFF8};
    vecs[7] = '{0, 0, 1'b0, 32'h0,          32'hFFFF_FFFC};
    vecs[8] = '{0, 0, 1'b0, 32'h0,          32'h0000_0000};

    reset = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    advance = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_opcode", {25'b0, opcode}, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("req_after_rst", {31'b0, imem_req}, 32'd1);

    for (int i = 0; i < 9; i++)
      do_step(vecs[i].lat, vecs[i].hold, vecs[i].redir, vecs[i].tgt, vecs[i].addr);

    // Reset in FETCH with an ack pending: ack seen only while reset is high.
    imem_ack = 1'b1; imem_rdata = 32'h1234_5677;
    #2 reset = 1'b1;
    #1;
    chk("rf_req", {31'b0, imem_req}, 32'd0);
    chk("rf_valid", {31'b0, instr_valid}, 32'd0);
    chk("rf_pc", pc, 32'h0);
    @(negedge clk);
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rf_req_rel", {31'b0, imem_req}, 32'd1);
    chk("rf_addr_rel", imem_addr, 32'h0);
    @(negedge clk);
    chk("rf_late_ack", {31'b0, instr_valid}, 32'd0);
    do_step(0, 0, 1'b0, 32'h0, 32'h0);

    // Reset in VALID at pc 4.
    chk("rv_addr", imem_addr, 32'h4);
    imem_ack = 1'b1; imem_rdata = mem_word(32'h4);
    @(negedge clk);
    imem_ack = 1'b0;
    chk("rv_valid", {31'b0, instr_valid}, 32'd1);
    chk("rv_instr", instr, mem_word(32'h4));
    #2 reset = 1'b1;
    #1;
    chk("rv_valid_rst", {31'b0, instr_valid}, 32'd0);
    chk("rv_instr_rst", instr, 32'h0);
    chk("rv_req_rst", {31'b0, imem_req}, 32'd0);
    chk("rv_pc_rst", pc, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Wrap on the instance that starts at 32'hFFFF_FFFC.
    #1;
    chk("wr_req", {31'b0, u1_req}, 32'd1);
    chk("wr_addr0", u1_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1; imem_rdata = mem_word(32'hFFFF_FFFC);
    @(negedge clk);
    imem_ack = 1'b0;
    chk("wr_valid", {31'b0, u1_valid}, 32'd1);
    chk("wr_pc", u1_pc, 32'hFFFF_FFFC);
    chk("wr_pc_plus4", u1_pc_plus4, 32'h0);
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
    chk("wr_req2", {31'b0, u1_req}, 32'd1);
    chk("wr_addr1", u1_addr, 32'h0);
    chk("wr_fault", {31'b0, u1_fault}, 32'd0);

    // Misaligned redirect from pc 4 of the main instance.
    do_step(0, 0, 1'b1, 32'h0000_0102, 32'h4);
    chk("mf_fault", {31'b0, fetch_fault}, 32'd1);
    chk("mf_pc", pc, 32'h0000_0102);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0033;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("mf_req", {31'b0, imem_req}, 32'd0);
    end
    chk("mf_fault_sticky", {31'b0, fetch_fault}, 32'd1);
    chk("mf_valid", {31'b0, instr_valid}, 32'd0);
    chk("mf_instr", instr, 32'h0);
    imem_ack = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mf_fault_clr", {31'b0, fetch_fault}, 32'd0);
    chk("mf_pc_rst", pc, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mf_req_rel", {31'b0, imem_req}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the single-cycle RISC-V core. Holds the program counter and fetches one 32-bit instruction per step from instruction memory over a req/ack handshake. It presents the instruction and its opcode field to the main control unit and the decode logic. It advances the PC by 4, or to a branch/jump target, when the core signals completion of the current instruction.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset; must be a multiple of 4
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address (= pc)
- imem_ack  in  1  memory has valid data on imem_rdata this cycle
- imem_rdata  in  32  instruction word from memory
- advance  in  1  core has finished executing the presented instruction
- redirect  in  1  branch taken / jump; qualified by advance
- redirect_pc  in  32  target address when redirect=1
- instr  out  32  current instruction; 32'h0000_0000 when instr_valid=0
- opcode  out  7  instr[6:0], feeds control unit opcode input
- pc  out  32  address of current instruction
- pc_plus4  out  32  pc + 4, modulo 2^32
- instr_valid  out  1  instr/opcode/pc are valid for execution
- fetch_fault  out  1  sticky misaligned-target fault

## Operation
- States: FETCH, VALID, FAULT. Reset state is FETCH.
- Reset values:
  - pc=RESET_PC
  - internal instruction register = 0
  - instr_valid=0, instr=0, opcode=0
  - fetch_fault=0
  - imem_req=0 while reset is asserted
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - imem_addr stays stable until ack.
  - On imem_ack=1: latch imem_rdata and go to VALID.
  - redirect and advance are ignored in this state.
- VALID:
  - instr_valid=1, imem_req=0.
  - instr, opcode and pc are stable until the state is left.
  - advance=0: hold.
  - advance=1, redirect=0: pc<=pc+4, go to FETCH.
  - advance=1, redirect=1, redirect_pc[1:0]==0: pc<=redirect_pc, go to FETCH.
  - advance=1, redirect=1, redirect_pc[1:0]!=0: pc<=redirect_pc, go to FAULT.
- FAULT:
  - fetch_fault=1, instr_valid=0, imem_req=0, instr=0.
  - Exit only via reset.
- Zero instr when invalid: opcode 0 decodes to the control unit's default case, so no register, memory or branch side effects occur while fetching.
- imem_ack is ignored whenever imem_req=0, including in VALID, FAULT and reset.
- PC arithmetic is 32-bit unsigned. pc=32'hFFFF_FFFC advances to 32'h0000_0000 with no fault. pc_plus4 is combinational from pc.
- redirect with advance=0 is ignored; the target is not stored.

## Timing
- First imem_req=1 is driven in the first cycle after reset deasserts (the state is already FETCH; the output is gated only by reset).
- imem_ack sampled at edge N → instr_valid=1 from cycle N+1.
- advance sampled at edge M → instr_valid=0 and imem_req=1 with the new pc from cycle M+1.
- Zero-wait memory (ack in the first request cycle) gives a minimum of 2 cycles per instruction.
- Reset mid-operation, any state:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - An outstanding request is abandoned.
  - Instruction memory must not hold ack across reset.
- Simultaneous advance and imem_ack in VALID: only advance acts.

## Test plan
- Reset release, memory returns 32'h0000_0013 at addr 0 with 2-cycle latency -> imem_req=1 with addr 0; instr_valid rises the cycle after ack; opcode=7'b0010011; pc=0; pc_plus4=4.
- Sequential fetch with immediate ack, advance pulsed whenever instr_valid=1 -> addresses 0, 4, 8, 12; each instr_valid=1 for exactly one cycle per advance; instr=0 in gaps.
- In VALID: advance=1, redirect=1, redirect_pc=32'h0000_0100 -> next imem_addr=0x100. Then redirect=1 with advance=0 for 3 cycles -> no state or pc change.
- Misaligned target: redirect_pc=32'h0000_0102 with advance=1 -> fetch_fault=1, pc=0x102, imem_req stays 0 for 20 cycles; reset clears fault and pc returns to RESET_PC.
- Wrap: RESET_PC=32'hFFFF_FFFC, fetch and advance -> second imem_addr=0, no fault.
- Assert reset while in FETCH with ack pending, and again while in VALID -> instr_valid=0, imem_req=0, pc=RESET_PC without a clock edge; a late imem_ack is ignored.
